// File: rtl/sm_fv_bank_rx.sv
// rtl/sm_fv_bank_rx.sv - small FV bank receive/serve controller
//
// Captures the sos/eos/A/FV_data beat stream from the big FV bank into the
// local small FV SRAM. It also serves node feature-vector reads to the Edge PEs
// as an sos/eos line stream tagged with the requesting PE.
//
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   in_sos/in_eos/in_addr/in_data  incoming beat stream (beat valid on sos,
//                                  and on every cycle while receiving)
//   rd_req/rd_node_id/rd_fv_num/rd_pe_tag  Edge PE read request
//   rd_ready                    request acceptance (IDLE only)
//   bank_valid                  bank holds a complete stream
//   sram_cen/sram_wen/sram_addr/sram_wdata/sram_rdata  SRAM macro port
//   pe_sos/pe_eos/pe_data/pe_tag  read line stream to Edge PEs
module sm_fv_bank_rx #(
  parameter int FV_BW          = 128,
  parameter int ADDR_W         = 9,
  parameter int LINES_PER_NODE = 8,
  parameter int NUM_PE         = 4,
  parameter int FVN_W          = 5
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      in_sos,
  input  logic                                      in_eos,
  input  logic [ADDR_W-1:0]                         in_addr,
  input  logic [FV_BW-1:0]                          in_data,
  input  logic                                      rd_req,
  input  logic [ADDR_W-$clog2(LINES_PER_NODE)-1:0]  rd_node_id,
  input  logic [FVN_W-1:0]                          rd_fv_num,
  input  logic [$clog2(NUM_PE)-1:0]                 rd_pe_tag,
  output logic                                      rd_ready,
  output logic                                      bank_valid,
  output logic                                      sram_cen,
  output logic                                      sram_wen,
  output logic [ADDR_W-1:0]                         sram_addr,
  output logic [FV_BW-1:0]                          sram_wdata,
  input  logic [FV_BW-1:0]                          sram_rdata,
  output logic                                      pe_sos,
  output logic                                      pe_eos,
  output logic [FV_BW-1:0]                          pe_data,
  output logic [$clog2(NUM_PE)-1:0]                 pe_tag
);

  localparam int LPN_W = $clog2(LINES_PER_NODE);
  localparam int CNT_W = LPN_W + 1;
  localparam int TAG_W = $clog2(NUM_PE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_RD   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    lines_q, lines_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                bank_valid_q, bank_valid_d;

  // Two feature values per line: lines = ceil(fv_num/2), at least one line
  // and never more than the lines reserved per node.
  logic [FVN_W:0]      half_lines;
  logic [CNT_W-1:0]    req_lines;

  always_comb begin
    half_lines = ({1'b0, rd_fv_num} + (FVN_W+1)'(1)) >> 1;
    if (half_lines == '0)
      req_lines = CNT_W'(1);
    else if (half_lines > (FVN_W+1)'(LINES_PER_NODE))
      req_lines = CNT_W'(LINES_PER_NODE);
    else
      req_lines = CNT_W'(half_lines);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lines_q      <= '0;
      tag_q        <= '0;
      base_q       <= '0;
      bank_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lines_q      <= lines_d;
      tag_q        <= tag_d;
      base_q       <= base_d;
      bank_valid_q <= bank_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lines_d      = lines_q;
    tag_d        = tag_q;
    base_d       = base_q;
    bank_valid_d = bank_valid_q;
    sram_cen     = 1'b1;
    sram_wen     = 1'b1;
    sram_addr    = '0;
    sram_wdata   = '0;
    pe_sos       = 1'b0;
    pe_eos       = 1'b0;
    pe_data      = '0;
    pe_tag       = '0;

    case (state_q)
      S_IDLE: begin
        if (in_sos) begin
          // A new stream always wins the port; a simultaneous read is dropped.
          sram_cen     = 1'b0;
          sram_wen     = 1'b0;
          sram_addr    = in_addr;
          sram_wdata   = in_data;
          bank_valid_d = in_eos;
          state_d      = in_eos ? S_IDLE : S_RECV;
        end else if (rd_req) begin
          tag_d     = rd_pe_tag;
          lines_d   = req_lines;
          base_d    = {rd_node_id, {LPN_W{1'b0}}};
          sram_cen  = 1'b0;
          sram_addr = {rd_node_id, {LPN_W{1'b0}}};
          cnt_d     = CNT_W'(1);
          state_d   = S_RD;
        end
      end

      S_RECV: begin
        // Every cycle inside a stream carries a beat; a stray sos is just data.
        sram_cen   = 1'b0;
        sram_wen   = 1'b0;
        sram_addr  = in_addr;
        sram_wdata = in_data;
        if (in_eos) begin
          bank_valid_d = 1'b1;
          state_d      = S_IDLE;
        end
      end

      S_RD: begin
        // cnt_q is the 1-based index of the line currently on sram_rdata.
        pe_data = sram_rdata;
        pe_tag  = tag_q;
        pe_sos  = (cnt_q == CNT_W'(1));
        if (in_sos) begin
          // Incoming stream pre-empts the read: this line closes the read.
          sram_cen     = 1'b0;
          sram_wen     = 1'b0;
          sram_addr    = in_addr;
          sram_wdata   = in_data;
          pe_eos       = 1'b1;
          cnt_d        = '0;
          bank_valid_d = in_eos;
          state_d      = in_eos ? S_IDLE : S_RECV;
        end else if (cnt_q == lines_q) begin
          pe_eos  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          sram_cen  = 1'b0;
          sram_addr = base_q + ADDR_W'(cnt_q);
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // While reset is asserted the SRAM and PE ports must already be quiet,
    // before the state register has been cleared by a clock edge.
    if (!reset) begin
      sram_cen   = 1'b1;
      sram_wen   = 1'b1;
      sram_addr  = '0;
      sram_wdata = '0;
      pe_sos     = 1'b0;
      pe_eos     = 1'b0;
      pe_data    = '0;
      pe_tag     = '0;
    end
  end

  assign rd_ready   = (state_q == S_IDLE);
  assign bank_valid = bank_valid_q;

endmodule
